fdtd_mem_stream_rd: RTL and testbench

Read-stream sequencer sitting directly upstream of the FDTD single-word AXI read port. It walks a programmed range of word addresses, drives that port's `rd_req`/`rd_word_addr`/`rd_gnt` handshake one word at a time, and buffers the returned words in a small FIFO. The FIFO presents them as a valid/ready stream to the FDTD update datapath.

---
 rtl/fdtd_mem_stream_rd.sv | 156 +++++++++++++++
 tb/tb_fdtd_mem_stream_rd.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_mem_stream_rd.sv
// Read-stream sequencer: walks a word-address range through the single-word read port and
// buffers returned words in a show-ahead FIFO. Optional stride input under FDTD_RD_STRIDE_EN.
module fdtd_mem_stream_rd #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_word_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef FDTD_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_word_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_gnt_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   stride_w;

  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    gnt, push, pop;

`ifdef FDTD_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0]   stride_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stride_q <= '0;
    end else if (state_q == StIdle && start_i && len_i != '0) begin
      stride_q <= stride_i;
    end
  end

  assign stride_w = stride_q;
`else
  assign stride_w = ADDR_WIDTH'(1);
`endif

  // Grants are only honoured while a read is actually outstanding.
  assign gnt     = rd_gnt_i & req_q;
  assign valid_o = (cnt_q != '0);
  assign pop     = valid_o & ready_i;
  assign push    = gnt & ((cnt_q != DepthCnt) | pop);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wptr_q] <= rd_data_i;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    req_d   = req_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d  = base_word_addr_i;
            rem_d   = len_i;
            req_d   = 1'b1;
            state_d = StReq;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (gnt) begin
          addr_d = addr_q + stride_w;
          rem_d  = rem_q - LEN_WIDTH'(1);
          // Next request needs room for the word it will bring back.
          req_d  = (rem_q != LEN_WIDTH'(1)) & (cnt_d < DepthCnt);
          if (rem_q == LEN_WIDTH'(1)) state_d = StDrain;
        end else if (!req_q && cnt_q < DepthCnt) begin
          req_d = 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  // The read port registers its request; masking with the grant avoids a spurious re-read.
  assign rd_req_o       = req_q & ~rd_gnt_i;
  assign rd_word_addr_o = addr_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign data_o         = valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_fdtd_mem_stream_rd.sv
// Directed bench for fdtd_mem_stream_rd with a two-cycle read-port responder model.
module tb_fdtd_mem_stream_rd;

  logic        ACLK;
  logic        ARESETn;
  logic        start_i;
  logic [29:0] base_word_addr_i;
  logic [15:0] len_i;
`ifdef FDTD_RD_STRIDE_EN
  logic [29:0] stride_i;
`endif
  logic        busy_o, done_o, rd_req_o;
  logic [29:0] rd_word_addr_o;
  logic [31:0] rd_data_i;
  logic        rd_gnt_i;
  logic [31:0] data_o;
  logic        valid_o, ready_i;

  int checks   = 0;
  int failures = 0;
  int gnt_cnt  = 0;
  int done_cnt = 0;
  logic [29:0] addr_log [$];
  logic [31:0] pop_log  [$];
  logic [29:0] resp_a;

  fdtd_mem_stream_rd dut (
    .ACLK             (ACLK),
    .ARESETn          (ARESETn),
    .start_i          (start_i),
    .base_word_addr_i (base_word_addr_i),
    .len_i            (len_i),
`ifdef FDTD_RD_STRIDE_EN
    .stride_i         (stride_i),
`endif
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rd_req_o         (rd_req_o),
    .rd_word_addr_o   (rd_word_addr_o),
    .rd_data_i        (rd_data_i),
    .rd_gnt_i         (rd_gnt_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  function automatic logic [31:0] dat(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  // Read port: captures a request, grants one cycle later with address-derived data.
  initial begin
    rd_gnt_i  = 1'b0;
    rd_data_i = '0;
    forever begin
      @(negedge ACLK);
      if (rd_req_o) begin
        resp_a = rd_word_addr_o;
        addr_log.push_back(resp_a);
        gnt_cnt++;
        @(posedge ACLK); #1;
        rd_gnt_i  = 1'b1;
        rd_data_i = dat(resp_a);
        @(posedge ACLK); #1;
        rd_gnt_i  = 1'b0;
        rd_data_i = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge ACLK);
      if (valid_o && ready_i) pop_log.push_back(data_o);
      if (done_o) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    pop_log.delete();
    gnt_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic start_cmd(input logic [29:0] base, input logic [15:0] len,
                           input logic [29:0] stride);
    @(posedge ACLK); #1;
    start_i          = 1'b1;
    base_word_addr_i = base;
    len_i            = len;
`ifdef FDTD_RD_STRIDE_EN
    stride_i         = stride;
`else
    if (stride != 30'd1) $display("note: stride %0d ignored in fixed-stride build", stride);
`endif
    @(posedge ACLK); #1;
    start_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   rd_req_o,       0);
    chk({tag, "_addr"},  rd_word_addr_o, 0);
    chk({tag, "_busy"},  busy_o,         0);
    chk({tag, "_done"},  done_o,         0);
    chk({tag, "_valid"}, valid_o,        0);
    chk({tag, "_data"},  data_o,         0);
  endtask

  // Toggle_ready alternates ready_i every cycle while waiting, so pops collide with grants.
  task automatic wait_done(input string tag, input int budget, input bit toggle_ready);
    int n = 0;
    while (!done_o && n < budget) begin
      @(posedge ACLK); #1;
      n++;
      if (toggle_ready && !done_o) ready_i = ~ready_i;
    end
    chk({tag, "_done_seen"}, done_o, 1);
    chk({tag, "_busy_at_done"}, busy_o, 0);
    @(posedge ACLK); #1;
    chk({tag, "_done_pulse"}, done_o, 0);
    ready_i = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk({tag, "_done_cnt"}, done_cnt, 1);
  endtask

  task automatic check_stream(input string tag, input logic [29:0] base,
                              input logic [29:0] stride, input int n);
    logic [29:0] a;
    a = base;
    chk({tag, "_nreq"}, addr_log.size(), n);
    chk({tag, "_npop"}, pop_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < addr_log.size()) chk($sformatf("%s_addr%0d", tag, i), addr_log[i], a);
      if (i < pop_log.size())  chk($sformatf("%s_data%0d", tag, i), pop_log[i], dat(a));
      a = a + stride;
    end
  endtask

  initial begin
    ARESETn          = 1'b0;
    start_i          = 1'b0;
    base_word_addr_i = '0;
    len_i            = '0;
`ifdef FDTD_RD_STRIDE_EN
    stride_i         = '0;
`endif
    ready_i          = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset("rst");
    ARESETn = 1'b1;

    // Contiguous read with an always-ready consumer.
    clear_logs();
    ready_i = 1'b1;
    start_cmd(30'h100, 16'd3, 30'd1);
    chk("t1_req_rise", rd_req_o, 1);
    chk("t1_busy", busy_o, 1);
    wait_done("t1", 200, 1'b0);
    check_stream("t1", 30'h100, 30'd1, 3);

    // Backpressure: FIFO fills, requests stop, a second start is ignored.
    clear_logs();
    ready_i = 1'b0;
    start_cmd(30'h200, 16'd6, 30'd1);
    repeat (30) @(posedge ACLK);
    #1;
    chk("t2_gnts_full", gnt_cnt, 4);
    chk("t2_req_low", rd_req_o, 0);
    chk("t2_valid", valid_o, 1);
    chk("t2_head", data_o, dat(30'h200));
    chk("t2_busy", busy_o, 1);
    start_cmd(30'h900, 16'd5, 30'd1);
    repeat (10) @(posedge ACLK);
    #1;
    chk("t2_restart_ignored", gnt_cnt, 4);
    wait_done("t2", 300, 1'b1);
    check_stream("t2", 30'h200, 30'd1, 6);

    // Zero-length command.
    clear_logs();
    start_cmd(30'h300, 16'd0, 30'd1);
    chk("t3_done", done_o, 1);
    chk("t3_busy", busy_o, 0);
    chk("t3_req", rd_req_o, 0);
    @(posedge ACLK); #1;
    chk("t3_done_pulse", done_o, 0);
    chk("t3_busy_after", busy_o, 0);
    repeat (3) @(posedge ACLK);
    #1;
    chk("t3_no_reads", gnt_cnt, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // Address wrap-around at the top of the word-address space.
    clear_logs();
`ifdef FDTD_RD_STRIDE_EN
    start_cmd(30'h3FFF_FFFE, 16'd2, 30'd4);
    wait_done("t4", 200, 1'b0);
    check_stream("t4", 30'h3FFF_FFFE, 30'd4, 2);
`else
    start_cmd(30'h3FFF_FFFF, 16'd2, 30'd1);
    wait_done("t4", 200, 1'b0);
    check_stream("t4", 30'h3FFF_FFFF, 30'd1, 2);
`endif

    // Reset mid-command, then a fresh command from a new base.
    clear_logs();
    ready_i = 1'b0;
    start_cmd(30'h400, 16'd6, 30'd1);
    repeat (3) @(posedge ACLK);
    #1;
    chk("t5_busy_before", busy_o, 1);
    ARESETn = 1'b0;
    #1;
    chk_reset("t5_rst");
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    clear_logs();
    ready_i = 1'b1;
    start_cmd(30'h500, 16'd2, 30'd1);
    wait_done("t5", 200, 1'b0);
    check_stream("t5", 30'h500, 30'd1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
